fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with a registered decode interface.
//
// Issues one instruction-memory read per cycle (1-cycle read latency), tags
// each request with its PC, and forwards responses into the decode register.
// A one-entry skid buffer catches the response that lands while decode is
// stalled, so releasing a stall costs no bubble. A redirect from execute wins
// over a stall, inserts exactly one bubble and flushes the skid entry.
//
// Parameters
//   INSTR_W   instruction word width
//   PC_W      program-counter width (all PC arithmetic is modulo 2^PC_W)
//   PC_STEP   sequential PC increment
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          in   clock, all state updates on its rising edge
//   rst          in   synchronous active-high reset
//   stall_d      in   decode not ready: hold decode outputs and fetch PC
//   pc_src_e     in   redirect request from execute
//   pc_target_e  in   redirect target (used unmodified)
//   imem_en      out  instruction-memory read strobe (combinational)
//   imem_addr    out  instruction-memory read address (combinational)
//   imem_rdata   in   read data, valid the cycle after an imem_en cycle
//   instr_d      out  registered instruction to decode
//   pc_d         out  registered PC of instr_d
//   pc_plus_d    out  registered pc_d + PC_STEP
//   valid_d      out  decode register holds a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned INSTR_W  = 34,
    parameter int unsigned PC_W     = 9,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_d,
    input  logic               pc_src_e,
    input  logic [PC_W-1:0]    pc_target_e,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_d,
    output logic [PC_W-1:0]    pc_plus_d,
    output logic               valid_d
);

    localparam logic [PC_W-1:0] Step    = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

    // Fetch PC and in-flight request tag
    logic [PC_W-1:0]    pc_f_q, pc_f_d;
    logic               req_valid_q, req_valid_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;

    // One-entry skid buffer
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

    // Decode register
    logic [INSTR_W-1:0] instr_q, instr_d_nxt;
    logic [PC_W-1:0]    pc_q, pc_d_nxt;
    logic [PC_W-1:0]    pc_plus_q, pc_plus_d_nxt;
    logic               valid_q, valid_d_nxt;

    // Request side: a redirect always fetches its target, even under stall,
    // so the target is already in flight when the stall lifts.
    always_comb begin
        imem_en   = !rst && (pc_src_e || !stall_d);
        imem_addr = pc_src_e ? pc_target_e : pc_f_q;

        pc_f_d      = pc_f_q;
        req_pc_d    = req_pc_q;
        req_valid_d = 1'b0;
        if (imem_en) begin
            req_valid_d = 1'b1;
            req_pc_d    = imem_addr;
            pc_f_d      = imem_addr + Step;
        end
    end

    // Response side: route the returning word to decode, skid, or discard.
    always_comb begin
        instr_d_nxt   = instr_q;
        pc_d_nxt      = pc_q;
        pc_plus_d_nxt = pc_plus_q;
        valid_d_nxt   = valid_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        if (pc_src_e) begin
            // Redirect: bubble into decode, drop skid and the wrong-path response
            instr_d_nxt   = '0;
            pc_d_nxt      = '0;
            pc_plus_d_nxt = '0;
            valid_d_nxt   = 1'b0;
            skid_valid_d  = 1'b0;
        end else if (!stall_d) begin
            if (skid_valid_q) begin
                // Skid entry is older than anything in flight (none can be)
                instr_d_nxt   = skid_instr_q;
                pc_d_nxt      = skid_pc_q;
                pc_plus_d_nxt = skid_pc_q + Step;
                valid_d_nxt   = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (req_valid_q) begin
                instr_d_nxt   = imem_rdata;
                pc_d_nxt      = req_pc_q;
                pc_plus_d_nxt = req_pc_q + Step;
                valid_d_nxt   = 1'b1;
            end else begin
                instr_d_nxt   = '0;
                pc_d_nxt      = '0;
                pc_plus_d_nxt = '0;
                valid_d_nxt   = 1'b0;
            end
        end else if (req_valid_q) begin
            // Stalled: the memory will not hold its data, so park it here
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q       <= ResetPc;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            instr_q      <= '0;
            pc_q         <= '0;
            pc_plus_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            pc_f_q       <= pc_f_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d_nxt;
            pc_q         <= pc_d_nxt;
            pc_plus_q    <= pc_plus_d_nxt;
            valid_q      <= valid_d_nxt;
        end
    end

    // A skid entry is only captured while stalled with no new fetch, so a
    // request can never be in flight alongside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(skid_valid_q && req_valid_q))
                else $error("skid entry and in-flight request coexist");
        end
    end

    assign instr_d   = instr_q;
    assign pc_d      = pc_q;
    assign pc_plus_d = pc_plus_q;
    assign valid_d   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// Memory returns mem[a] = a + 0x100 one cycle after an imem_en cycle and
// random junk otherwise. The reference model tracks only the program-order
// stream: the next PC owed to decode and whether it has already been
// requested. Directed cycles cover start-up, wrap at 0x1FC, redirect under
// stall and reset with a full skid; the remainder is random.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned INSTR_W  = 34;
    localparam int unsigned PC_W     = 9;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned RESET_PC = 0;
    localparam int          NCycles  = 3000;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall_d;
    logic               pc_src_e;
    logic [PC_W-1:0]    pc_target_e;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_plus_d;
    logic               valid_d;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    fetch_unit #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall_d     (stall_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus_d   (pc_plus_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one-cycle latency; junk when not read
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= INSTR_W'(imem_addr) + INSTR_W'(32'h100);
        else         imem_rdata <= INSTR_W'({$urandom(), $urandom()});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: decode contents plus the program-order stream
    logic            m_valid;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_next;   // next PC owed to decode
    logic            m_avail;  // m_next already requested from memory

    task automatic model_step(input logic r, input logic st, input logic rd,
                              input logic [PC_W-1:0] tg);
        if (r) begin
            m_valid = 1'b0; m_pc = '0; m_next = PC_W'(RESET_PC); m_avail = 1'b0;
        end else if (rd) begin
            m_valid = 1'b0; m_pc = '0; m_next = tg; m_avail = 1'b1;
        end else if (!st) begin
            if (m_avail) begin
                m_valid = 1'b1; m_pc = m_next; m_next = m_next + PC_W'(PC_STEP);
            end else begin
                m_valid = 1'b0; m_pc = '0;
            end
            m_avail = 1'b1;
        end
    endtask

    initial begin
        logic            r, st, rd;
        logic [PC_W-1:0] tg;
        logic [PC_W-1:0] exp_addr;
        logic [PC_W-1:0] exp_plus;

        m_valid = 1'b0; m_pc = '0; m_next = PC_W'(RESET_PC); m_avail = 1'b0;

        for (int i = 0; i < NCycles; i++) begin
            cyc = i;
            r = 1'b0; st = 1'b0; rd = 1'b0; tg = PC_W'($urandom());
            if (i < 2) r = 1'b1;
            else if (i < 40) begin
                case (i)
                    12:      begin rd = 1'b1; tg = 9'h1fc; end
                    16:      begin rd = 1'b1; st = 1'b1; tg = 9'h040; end
                    17, 18:  st = 1'b1;
                    22, 23:  st = 1'b1;
                    24:      begin st = 1'b1; r = 1'b1; end
                    30, 31, 32: st = 1'b1;
                    35:      begin rd = 1'b1; tg = 9'h040; end
                    default: ;
                endcase
            end else begin
                st = ($urandom_range(99) < 30);
                rd = ($urandom_range(99) < 10);
                r  = ($urandom_range(199) == 0);
                if (rd && $urandom_range(3) == 0) tg = 9'h1fc;
            end

            rst = r; stall_d = st; pc_src_e = rd; pc_target_e = tg;
            #1;
            check_eq("imem_en", 64'(imem_en), 64'(!r && (rd || !st)));
            if (!r && i > 0) begin
                if (rd)           exp_addr = tg;
                else if (m_avail) exp_addr = m_next + PC_W'(PC_STEP);
                else              exp_addr = m_next;
                check_eq("imem_addr", 64'(imem_addr), 64'(exp_addr));
            end

            model_step(r, st, rd, tg);
            @(negedge clk);

            exp_plus = m_valid ? m_pc + PC_W'(PC_STEP) : '0;
            check_eq("valid_d", 64'(valid_d), 64'(m_valid));
            check_eq("pc_d", 64'(pc_d), 64'(m_pc));
            check_eq("pc_plus_d", 64'(pc_plus_d), 64'(exp_plus));
            check_eq("instr_d", 64'(instr_d),
                     m_valid ? 64'(m_pc) + 64'h100 : 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
